rgb_pwm: RTL and testbench

RGB_PWM -- requirements
Module: rgb_pwm

---
 rtl/rgb_pwm.sv | 110 +++++++++++
 tb/tb_rgb_pwm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel PWM LED driver with shadowed duty registers.
// Duty updates are captured into a shadow copy and only applied at the
// period boundary, so a running period never shows a partial duty.
// Loads taken while stopped, or on the boundary cycle itself, go
// straight into the active registers.
module rgb_pwm #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] red_duty,
  input  logic [WIDTH-1:0] green_duty,
  input  logic [WIDTH-1:0] blue_duty,
  output logic             led_nr,
  output logic             led_ng,
  output logic             led_nb,
  output logic             pending,
  output logic             period_start
);

  localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);
  // Last step of a period; the counter never reaches 2^WIDTH-1, so a duty
  // of all ones stays lit straight through the wrap.
  localparam logic [WIDTH-1:0] CMAX = WIDTH'((1 << WIDTH) - 2);

  logic [PW-1:0]          presc_q, presc_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [2:0][WIDTH-1:0]  act_q, act_d;
  logic [2:0][WIDTH-1:0]  shd_q, shd_d;
  logic                   pend_q, pend_d;
  logic                   ps_q, ps_d;
  logic [2:0]             led_n_q, led_n_d;

  logic                   tick, bnd;
  logic [2:0][WIDTH-1:0]  duty_in;

  assign duty_in = {blue_duty, green_duty, red_duty};
  assign tick    = enable && (presc_q == PMAX);
  assign bnd     = tick && (cnt_q == CMAX);

  // Next-state: prescaler, step counter, duty shadow/active and LED drive.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    ps_d    = bnd;
    led_n_d = '1;

    // Counters sit at zero while stopped, so re-enabling starts a fresh period.
    if (!enable) begin
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
      if (tick) cnt_d = (cnt_q == CMAX) ? '0 : cnt_q + WIDTH'(1);
    end

    // Stopped or at the boundary: flush shadow into active; a same-cycle
    // load is newer than the shadow and takes precedence.
    if (!enable || bnd) begin
      if (load) begin
        act_d = duty_in;
        shd_d = duty_in;
      end else if (pend_q) begin
        act_d = shd_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      shd_d  = duty_in;
      pend_d = 1'b1;
    end

    for (int i = 0; i < 3; i++)
      led_n_d[i] = !(enable && (cnt_q < act_q[i]));
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      ps_q    <= 1'b0;
      led_n_q <= '1;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      ps_q    <= ps_d;
      led_n_q <= led_n_d;
    end
  end

  assign led_nr       = led_n_q[0];
  assign led_ng       = led_n_q[1];
  assign led_nb       = led_n_q[2];
  assign pending      = pend_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// tb_rgb_pwm: directed scenarios for rgb_pwm (WIDTH=4, PRESCALE=2) with a
// cycle-position model checked every cycle, plus hand-counted lit windows.
module tb_rgb_pwm;
  localparam int W = 4, PS = 2, PER = 30;

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, load = 1'b0;
  logic [W-1:0] rd = '0, gd = '0, bd = '0;
  logic led_nr, led_ng, led_nb, pending, period_start;

  rgb_pwm #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .red_duty(rd), .green_duty(gd), .blue_duty(bd),
    .led_nr(led_nr), .led_ng(led_ng), .led_nb(led_nb),
    .pending(pending), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  bit chk_on = 0;

  task automatic check(input string n, input logic a, input logic e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
    end
  endtask

  task automatic checkint(input string n, input int a, input int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask

  // Model: pos is the clk cycle index inside the 30-cycle period.
  int pos = 0;
  int act[3] = '{0, 0, 0};
  int shd[3] = '{0, 0, 0};
  bit pend = 0;
  bit e_led[3] = '{1, 1, 1};
  bit e_pend = 0, e_ps = 0;

  always @(posedge clk or negedge reset_n) begin
    int d[3];
    bit bnd;
    if (!reset_n) begin
      pos = 0; act = '{0, 0, 0}; shd = '{0, 0, 0}; pend = 0;
      e_led = '{1, 1, 1}; e_pend = 0; e_ps = 0;
    end else begin
      d[0] = int'(rd); d[1] = int'(gd); d[2] = int'(bd);
      bnd = enable && (pos == PER - 1);
      for (int i = 0; i < 3; i++) e_led[i] = !(enable && (pos / PS < act[i]));
      e_ps = bnd;
      if (!enable || bnd) begin
        if (load) begin act = d; shd = d; end
        else if (pend) act = shd;
        pend = 0;
      end else if (load) begin
        shd = d; pend = 1;
      end
      e_pend = pend;
      pos = enable ? ((pos == PER - 1) ? 0 : pos + 1) : 0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("led_nr", led_nr, e_led[0]);
      check("led_ng", led_ng, e_led[1]);
      check("led_nb", led_nb, e_led[2]);
      check("pending", pending, e_pend);
      check("period_start", period_start, e_ps);
    end
  end

  task automatic pulse_load(input int r, input int g, input int b);
    rd = W'(r); gd = W'(g); bd = W'(b); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_ps();
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (period_start) seen = 1;
    end
    if (!seen) checkint("wait_period_start_timeout", 0, 1);
  endtask

  task automatic count_win(output int nr, output int ng, output int nb, output int nps);
    nr = 0; ng = 0; nb = 0; nps = 0;
    for (int k = 0; k < PER; k++) begin
      @(negedge clk);
      if (!led_nr) nr++;
      if (!led_ng) ng++;
      if (!led_nb) nb++;
      if (period_start) nps++;
    end
  endtask

  initial begin
    int r, g, b, p;
    repeat (3) @(negedge clk);
    check("rst_led_nr", led_nr, 1'b1);
    check("rst_led_ng", led_ng, 1'b1);
    check("rst_led_nb", led_nb, 1'b1);
    check("rst_pending", pending, 1'b0);
    check("rst_period_start", period_start, 1'b0);
    chk_on = 1;
    reset_n = 1'b1;
    @(negedge clk);

    // Load while stopped, then run.
    pulse_load(15, 0, 7);
    check("stopped_load_pending", pending, 1'b0);
    enable = 1'b1;
    count_win(r, g, b, p);
    checkint("full_red_lit", r, 30);
    checkint("zero_green_lit", g, 0);
    checkint("blue7_lit", b, 14);

    // Mid-period load is deferred to the boundary.
    wait_ps();
    repeat (5) @(negedge clk);
    pulse_load(3, 0, 7);
    check("midload_pending", pending, 1'b1);
    wait_ps();
    check("after_bnd_pending", pending, 1'b0);
    count_win(r, g, b, p);
    checkint("red3_lit", r, 6);

    // Last load before the boundary wins.
    wait_ps();
    repeat (3) @(negedge clk);
    pulse_load(5, 0, 7);
    repeat (3) @(negedge clk);
    pulse_load(9, 0, 7);
    wait_ps();
    count_win(r, g, b, p);
    checkint("red9_lit", r, 18);

    // Load exactly on the boundary cycle.
    wait_ps();
    repeat (29) @(negedge clk);
    pulse_load(2, 0, 7);
    check("bndload_pending", pending, 1'b0);
    check("bndload_ps", period_start, 1'b1);
    count_win(r, g, b, p);
    checkint("red2_lit", r, 4);

    // Disable with a load pending, then restart.
    wait_ps();
    repeat (4) @(negedge clk);
    pulse_load(11, 0, 7);
    check("pre_disable_pending", pending, 1'b1);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_led_nr", led_nr, 1'b1);
    check("dis_led_nb", led_nb, 1'b1);
    check("dis_pending", pending, 1'b0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    count_win(r, g, b, p);
    checkint("restart_red11_lit", r, 22);
    checkint("restart_ps_count", p, 1);

    // Asynchronous reset mid-period with LEDs lit and a load pending.
    wait_ps();
    repeat (2) @(negedge clk);
    pulse_load(13, 0, 7);
    check("prereset_red_lit", led_nr, 1'b0);
    check("prereset_pending", pending, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_led_nr", led_nr, 1'b1);
    check("async_led_ng", led_ng, 1'b1);
    check("async_led_nb", led_nb, 1'b1);
    check("async_pending", pending, 1'b0);
    check("async_ps", period_start, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    count_win(r, g, b, p);
    checkint("postreset_red_lit", r, 0);
    checkint("postreset_blue_lit", b, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
